id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand select, MEM/WB forwarding and hazard stall.
// Optional bypass network enabled by defining ID_EX_FORWARDING_EN.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [4:0]  alu_ctrl_i,
  input  logic        src_a_sel_i,
  input  logic        src_b_sel_i,
  input  logic        reg_write_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_reg_write_i,
  input  logic [31:0] mem_result_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        wb_reg_write_i,
  input  logic [31:0] wb_result_i,
  output logic [4:0]  ALUCtrl_o,
  output logic [31:0] SrcA_o,
  output logic [31:0] SrcB_o,
  output logic [31:0] store_data_o,
  output logic [31:0] pc_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        valid_o,
  output logic        hazard_stall_o
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  alu;
    logic        a_sel;
    logic        b_sel;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  id_ex_t id_w;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        load_use;
  logic        raw_stall;

  always_comb begin
    id_w           = '0;
    id_w.valid     = valid_i;
    id_w.pc        = pc_i;
    id_w.rs1_data  = rs1_data_i;
    id_w.rs2_data  = rs2_data_i;
    id_w.imm       = imm_i;
    id_w.rs1       = rs1_addr_i;
    id_w.rs2       = rs2_addr_i;
    id_w.rd        = rd_addr_i;
    id_w.alu       = alu_ctrl_i;
    id_w.a_sel     = src_a_sel_i;
    id_w.b_sel     = src_b_sel_i;
    id_w.reg_write = reg_write_i;
    id_w.mem_read  = mem_read_i;
    id_w.mem_write = mem_write_i;
  end

  // A load in EX cannot supply its data until MEM, so its consumer waits a cycle.
  always_comb begin
    load_use = valid_i && ex_q.valid && ex_q.mem_read
            && (ex_q.rd != 5'd0)
            && ((ex_q.rd == rs1_addr_i) || (ex_q.rd == rs2_addr_i));
  end

`ifdef ID_EX_FORWARDING_EN
  function automatic logic [31:0] bypass(
    input logic [4:0]  rs,
    input logic [31:0] rdat,
    input logic [4:0]  m_rd,
    input logic        m_we,
    input logic [31:0] m_res,
    input logic [4:0]  w_rd,
    input logic        w_we,
    input logic [31:0] w_res
  );
    logic [31:0] r;
    r = rdat;
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))
      r = m_res;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs))
      r = w_res;
    return r;
  endfunction

  always_comb begin
    fwd_a = bypass(ex_q.rs1, ex_q.rs1_data,
                   mem_rd_addr_i, mem_reg_write_i, mem_result_i,
                   wb_rd_addr_i, wb_reg_write_i, wb_result_i);
    fwd_b = bypass(ex_q.rs2, ex_q.rs2_data,
                   mem_rd_addr_i, mem_reg_write_i, mem_result_i,
                   wb_rd_addr_i, wb_reg_write_i, wb_result_i);
    raw_stall = 1'b0;
  end
`else
  function automatic logic raw_hit(
    input logic [4:0] rs,
    input logic       ex_we,
    input logic [4:0] ex_rd,
    input logic       m_we,
    input logic [4:0] m_rd
  );
    return (rs != 5'd0)
        && ((ex_we && (ex_rd == rs)) || (m_we && (m_rd == rs)));
  endfunction

  logic ex_we;
  logic unused_nofwd;

  // Without bypass, WB relies on a write-first regfile; EX and MEM must drain.
  always_comb begin
    ex_we     = ex_q.valid && ex_q.reg_write;
    fwd_a     = ex_q.rs1_data;
    fwd_b     = ex_q.rs2_data;
    raw_stall = valid_i
             && (raw_hit(rs1_addr_i, ex_we, ex_q.rd,
                         mem_reg_write_i, mem_rd_addr_i)
              || raw_hit(rs2_addr_i, ex_we, ex_q.rd,
                         mem_reg_write_i, mem_rd_addr_i));
  end

  assign unused_nofwd = ^{mem_result_i, wb_result_i, wb_rd_addr_i,
                          wb_reg_write_i, ex_q.rs1, ex_q.rs2};
`endif

  assign hazard_stall_o = !rst_i && (load_use || raw_stall);

  always_comb begin
    ex_d = ex_q;
    if (flush_i)
      ex_d = '0;
    else if (stall_i)
      ex_d = ex_q;
    else if (hazard_stall_o || !valid_i)
      ex_d = '0;
    else
      ex_d = id_w;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign ALUCtrl_o    = ex_q.alu;
  assign SrcA_o       = ex_q.a_sel ? ex_q.pc : fwd_a;
  assign SrcB_o       = ex_q.b_sel ? ex_q.imm : fwd_b;
  assign store_data_o = fwd_b;
  assign pc_o         = ex_q.pc;
  assign rd_addr_o    = ex_q.rd;
  assign reg_write_o  = ex_q.reg_write;
  assign mem_read_o   = ex_q.mem_read;
  assign mem_write_o  = ex_q.mem_write;
  assign valid_o      = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage.
// Expectations follow the build's ID_EX_FORWARDING_EN setting.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stall_i, flush_i, valid_i;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, alu_ctrl_i;
  logic        src_a_sel_i, src_b_sel_i;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
  logic        mem_reg_write_i, wb_reg_write_i;
  logic [31:0] mem_result_i, wb_result_i;
  logic [4:0]  ALUCtrl_o, rd_addr_o;
  logic [31:0] SrcA_o, SrcB_o, store_data_o, pc_o;
  logic        reg_write_o, mem_read_o, mem_write_o;
  logic        valid_o, hazard_stall_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rd_addr_i(rd_addr_i), .alu_ctrl_i(alu_ctrl_i),
    .src_a_sel_i(src_a_sel_i), .src_b_sel_i(src_b_sel_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i),
    .mem_rd_addr_i(mem_rd_addr_i),
    .mem_reg_write_i(mem_reg_write_i),
    .mem_result_i(mem_result_i),
    .wb_rd_addr_i(wb_rd_addr_i),
    .wb_reg_write_i(wb_reg_write_i),
    .wb_result_i(wb_result_i),
    .ALUCtrl_o(ALUCtrl_o), .SrcA_o(SrcA_o), .SrcB_o(SrcB_o),
    .store_data_o(store_data_o), .pc_o(pc_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .valid_o(valid_o), .hazard_stall_o(hazard_stall_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  r1a, r2a, rd, alu;
    logic        as, bs, rw, mr, mw;
  } in_t;

  typedef struct {
    logic        hz, dchk, v;
    logic [4:0]  alu;
    logic [31:0] a, b, st, pc;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } out_t;

  typedef struct {
    in_t        i;
    logic       stall, flush;
    logic [4:0] mrd;
    logic       mrw;
    out_t       o;
  } vec_t;

  function automatic in_t mkin(
    input logic v, input logic [31:0] pc, r1d, r2d, imm,
    input logic [4:0] r1a, r2a, rd, alu,
    input logic as, bs, rw, mr, mw);
    in_t t;
    t.v = v; t.pc = pc; t.r1d = r1d; t.r2d = r2d; t.imm = imm;
    t.r1a = r1a; t.r2a = r2a; t.rd = rd; t.alu = alu;
    t.as = as; t.bs = bs; t.rw = rw; t.mr = mr; t.mw = mw;
    return t;
  endfunction

  function automatic out_t mkout(
    input logic hz, input logic [4:0] alu,
    input logic [31:0] a, b, st, pc,
    input logic [4:0] rd, input logic rw, mr, mw);
    out_t t;
    t.hz = hz; t.dchk = 1'b1; t.v = 1'b1; t.alu = alu;
    t.a = a; t.b = b; t.st = st; t.pc = pc;
    t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw;
    return t;
  endfunction

  function automatic out_t bub(input logic hz);
    out_t t;
    t = mkout(hz, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    t.v = 1'b0;
    t.dchk = 1'b0;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic drive(input in_t t);
    valid_i = t.v; pc_i = t.pc;
    rs1_data_i = t.r1d; rs2_data_i = t.r2d; imm_i = t.imm;
    rs1_addr_i = t.r1a; rs2_addr_i = t.r2a;
    rd_addr_i = t.rd; alu_ctrl_i = t.alu;
    src_a_sel_i = t.as; src_b_sel_i = t.bs;
    reg_write_i = t.rw; mem_read_i = t.mr; mem_write_i = t.mw;
  endtask

  task automatic chk_out(input string n, input out_t e);
    chk({n, ".valid"}, valid_o, e.v);
    chk({n, ".alu"}, ALUCtrl_o, e.alu);
    chk({n, ".rd"}, rd_addr_o, e.rd);
    chk({n, ".rw"}, reg_write_o, e.rw);
    chk({n, ".mr"}, mem_read_o, e.mr);
    chk({n, ".mw"}, mem_write_o, e.mw);
    if (e.dchk) begin
      chk({n, ".srca"}, SrcA_o, e.a);
      chk({n, ".srcb"}, SrcB_o, e.b);
      chk({n, ".store"}, store_data_o, e.st);
      chk({n, ".pc"}, pc_o, e.pc);
    end
  endtask

  task automatic step(input string n);
    @(posedge clk);
    #1;
    chk_out(n, '{default: '0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  vec_t  tv[11];
  out_t  e;
  in_t   hold;
  bit    fwd_en;

  initial begin
`ifdef ID_EX_FORWARDING_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    rst_i = 1'b1;
    stall_i = 0; flush_i = 0;
    drive(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    mem_rd_addr_i = 0; mem_reg_write_i = 0;
    mem_result_i = 32'hAAAA_AAAA;
    wb_rd_addr_i = 0; wb_reg_write_i = 0;
    wb_result_i = 32'hBBBB_BBBB;

    // capture, operand b from immediate
    tv[0].i = mkin(1, 32'h100, 5, 9, 7, 1, 2, 3, 0, 0, 1, 1, 0, 0);
    tv[0].o = mkout(0, 0, 5, 7, 9, 32'h100, 3, 1, 0, 0);
    // lw x4
    tv[1].i = mkin(1, 32'h104, 32'h20, 0, 8, 5, 0, 4, 0, 0, 1, 1, 1, 0);
    tv[1].o = mkout(0, 0, 32'h20, 8, 0, 32'h104, 4, 1, 1, 0);
    // add using x4: load-use bubble
    tv[2].i = mkin(1, 32'h108, 32'h11, 32'h22, 0, 6, 4, 7, 1, 0, 0, 1, 0, 0);
    tv[2].o = bub(1);
    // re-presented add
    tv[3].i = tv[2].i;
    tv[3].o = mkout(0, 1, 32'h11, 32'h22, 32'h22, 32'h108, 7, 1, 0, 0);
    // lw x0
    tv[4].i = mkin(1, 32'h10C, 32'h40, 5, 4, 8, 9, 0, 0, 0, 1, 1, 1, 0);
    tv[4].o = mkout(0, 0, 32'h40, 4, 5, 32'h10C, 0, 1, 1, 0);
    // reads x0 after lw x0: no stall, src a = pc
    tv[5].i = mkin(1, 32'h110, 1, 2, 0, 0, 0, 2, 2, 1, 0, 1, 0, 0);
    tv[5].o = mkout(0, 2, 32'h110, 2, 2, 32'h110, 2, 1, 0, 0);
    // invalid slot captured as bubble
    tv[6].i = mkin(0, 32'h114, 3, 4, 5, 2, 2, 9, 3, 0, 0, 1, 0, 1);
    tv[6].o = bub(0);
    // store
    tv[7].i = mkin(1, 32'h118, 32'h300, 32'hCAFE, 32'h10,
                   10, 11, 0, 0, 0, 1, 0, 0, 1);
    tv[7].o = mkout(0, 0, 32'h300, 32'h10, 32'hCAFE, 32'h118, 0, 0, 0, 1);
    // flush and stall on one edge
    tv[8].i = mkin(1, 32'h11C, 1, 1, 1, 1, 1, 5, 4, 0, 0, 1, 0, 0);
    tv[8].o = bub(0);
    // RAW against MEM-stage writer
    tv[9].i = mkin(1, 32'h120, 7, 8, 0, 12, 13, 14, 4, 0, 0, 1, 0, 0);
    if (fwd_en)
      tv[9].o = mkout(0, 4, 32'hAAAA_AAAA, 8, 8, 32'h120, 14, 1, 0, 0);
    else
      tv[9].o = bub(1);
    // MEM writer targets x0, ID reads x0
    tv[10].i = mkin(1, 32'h124, 9, 32'hA, 0, 0, 15, 16, 5, 0, 0, 1, 0, 0);
    tv[10].o = mkout(0, 5, 9, 32'hA, 32'hA, 32'h124, 16, 1, 0, 0);

    for (int k = 0; k < 11; k++) begin
      tv[k].stall = (k == 8);
      tv[k].flush = (k == 8);
      tv[k].mrd = (k == 9) ? 5'd12 : 5'd0;
      tv[k].mrw = (k >= 9);
    end

    #12;
    chk("rst.valid", valid_o, 0);
    chk("rst.alu", ALUCtrl_o, 0);
    chk("rst.pc", pc_o, 0);
    chk("rst.rw", reg_write_o, 0);
    chk("rst.hz", hazard_stall_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      drive(tv[k].i);
      stall_i = tv[k].stall;
      flush_i = tv[k].flush;
      mem_rd_addr_i = tv[k].mrd;
      mem_reg_write_i = tv[k].mrw;
      #1;
      chk($sformatf("v%0d.hz", k), hazard_stall_o, tv[k].o.hz);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", k), tv[k].o);
    end

    // stall hold for three cycles, then release
    @(negedge clk);
    stall_i = 0; flush_i = 0;
    mem_rd_addr_i = 0; mem_reg_write_i = 0;
    drive(mkin(1, 32'h200, 32'h31, 32'h32, 32'h33,
               17, 18, 19, 6, 0, 0, 1, 0, 0));
    e = mkout(0, 6, 32'h31, 32'h32, 32'h32, 32'h200, 19, 1, 0, 0);
    @(posedge clk);
    #1;
    chk_out("st.cap", e);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall_i = 1;
      drive(mkin(1, 32'h300 + 4 * k, k, k + 1, k + 2,
                 20, 21, 22, 7, 1, 1, 0, 1, 1));
      @(posedge clk);
      #1;
      chk_out($sformatf("st.hold%0d", k), e);
    end
    @(negedge clk);
    stall_i = 0;
    drive(mkin(1, 32'h400, 32'h41, 32'h42, 32'h43,
               20, 21, 22, 7, 0, 1, 1, 0, 0));
    @(posedge clk);
    #1;
    chk_out("st.rel", mkout(0, 7, 32'h41, 32'h43, 32'h42,
                            32'h400, 22, 1, 0, 0));

    // async reset between edges; hazard forced low while in reset
    @(negedge clk);
    mem_rd_addr_i = 20; mem_reg_write_i = 1;
    #2 rst_i = 1;
    #1;
    chk("ar.valid", valid_o, 0);
    chk("ar.alu", ALUCtrl_o, 0);
    chk("ar.pc", pc_o, 0);
    chk("ar.rd", rd_addr_o, 0);
    chk("ar.rw", reg_write_o, 0);
    chk("ar.hz", hazard_stall_o, 0);
    #1 rst_i = 0;
    mem_rd_addr_i = 0; mem_reg_write_i = 0;
    @(posedge clk);
    #1;
    chk("ar.post.valid", valid_o, 1);
    chk("ar.post.pc", pc_o, 32'h400);

    // reset during stall discards the held instruction
    @(negedge clk);
    stall_i = 1;
    drive(mkin(1, 32'h500, 32'h51, 32'h52, 32'h53,
               23, 24, 25, 8, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    chk("rs.held.pc", pc_o, 32'h400);
    @(negedge clk);
    #2 rst_i = 1;
    #2 rst_i = 0;
    stall_i = 0;
    #0;
    chk("rs.clr.valid", valid_o, 0);
    chk("rs.clr.pc", pc_o, 0);
    @(posedge clk);
    #1;
    chk_out("rs.cap", mkout(0, 8, 32'h51, 32'h52, 32'h52,
                            32'h500, 25, 1, 0, 0));

    // MEM/WB bypass priority and x0 exclusion
    @(negedge clk);
    drive(mkin(1, 32'h600, 32'h1234, 32'h5678, 0,
               3, 3, 8, 0, 0, 0, 1, 0, 0));
    @(posedge clk);
    #1;
    chk("fw.base", SrcA_o, 32'h1234);
    @(negedge clk);
    valid_i = 0;
    mem_rd_addr_i = 3; mem_reg_write_i = 1;
    wb_rd_addr_i = 3; wb_reg_write_i = 1;
    #1;
    chk("fw.mem.a", SrcA_o, fwd_en ? 32'hAAAA_AAAA : 32'h1234);
    chk("fw.mem.st", store_data_o, fwd_en ? 32'hAAAA_AAAA : 32'h5678);
    mem_reg_write_i = 0;
    #1;
    chk("fw.wb.a", SrcA_o, fwd_en ? 32'hBBBB_BBBB : 32'h1234);
    @(negedge clk);
    drive(mkin(1, 32'h604, 32'h55, 32'h66, 0,
               0, 0, 9, 0, 0, 0, 1, 0, 0));
    mem_rd_addr_i = 0; mem_reg_write_i = 1;
    wb_rd_addr_i = 0; wb_reg_write_i = 1;
    #1;
    chk("fw.x0.hz", hazard_stall_o, 0);
    @(posedge clk);
    #1;
    chk("fw.x0.a", SrcA_o, 32'h55);
    chk("fw.x0.b", SrcB_o, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
